// File: rtl/alu_arb_seq.sv
// alu_arb_seq: accepts one operation at a time from two requesters, runs it on the shared 8-bit ALU,
// and returns the captured result. Macro ALU_ARB_RR_EN selects round-robin; default is fixed priority (req0 first).
module alu_arb_seq #(
  parameter int unsigned LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] op0,
  input  logic [3:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       err,
  output logic       busy,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_sel,
  output logic [1:0] alu_fn,
  input  logic [7:0] alu_res
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       owner_q;
  logic       illegal_q;
  logic       gnt0_q, gnt1_q, done0_q, done1_q, err_q;
  logic [7:0] result_q;
  logic [7:0] alu_a_q, alu_b_q;
  logic [1:0] alu_sel_q, alu_fn_q;

  logic       pick1_d;
  logic [3:0] op_d;
  logic [7:0] a_d, b_d;
  logic       illegal_d;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    pick1_d = 1'b0;
    if (req0 && req1) begin
      pick1_d = ~last_q;
    end else begin
      pick1_d = req1;
    end
  end
`else
  always_comb begin
    pick1_d = 1'b0;
    pick1_d = !req0 && req1;
  end
`endif

  assign op_d      = pick1_d ? op1 : op0;
  assign a_d       = pick1_d ? a1  : a0;
  assign b_d       = pick1_d ? b1  : b0;
  assign illegal_d = (op_d[3:2] == 2'b11);

  // Single FSM: every output is a register so the ALU and requesters see glitch-free levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      owner_q   <= 1'b0;
      illegal_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= 8'h00;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_sel_q <= 2'b00;
      alu_fn_q  <= 2'b00;
`ifdef ALU_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt0_q    <= !pick1_d;
            gnt1_q    <= pick1_d;
            owner_q   <= pick1_d;
            illegal_q <= illegal_d;
            alu_a_q   <= a_d;
            alu_b_q   <= b_d;
            alu_sel_q <= illegal_d ? 2'b00 : op_d[3:2];
            alu_fn_q  <= illegal_d ? 2'b00 : op_d[1:0];
            cnt_q     <= CNT_INIT;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            result_q  <= illegal_q ? 8'h00 : alu_res;
            done0_q   <= !owner_q;
            done1_q   <= owner_q;
            err_q     <= illegal_q;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            alu_sel_q <= 2'b00;
            alu_fn_q  <= 2'b00;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
`ifdef ALU_ARB_RR_EN
          last_q  <= owner_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign err     = err_q;
  assign result  = result_q;
  assign busy    = (state_q != IDLE);
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign alu_fn  = alu_fn_q;

endmodule

// File: tb/tb_alu_arb_seq.sv
// tb_alu_arb_seq: directed bench with a scoreboard on the LAT=1 instance and cycle-exact checks
// on LAT=3 (timing) and LAT=4 (reset mid-operation) instances.
module tb_alu_arb_seq;

  typedef struct {
    logic       who;
    logic [7:0] res;
    logic       err;
  } expT;

  typedef struct {
    logic       who;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vecT;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  expT  expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stand-in for the ALU units plus result mux; compares return FF for true.
  function automatic logic [7:0] aluModel(input logic [1:0] sel, input logic [1:0] fn,
                                          input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (sel)
      2'b10: case (fn)
               2'b00: r = a + b;
               2'b01: r = a - b;
               2'b10: r = a + 8'd1;
               default: r = a - 8'd1;
             endcase
      2'b01: case (fn)
               2'b00: r = a & b;
               2'b01: r = a | b;
               2'b10: r = ~a;
               default: r = a ^ b;
             endcase
      2'b00: case (fn)
               2'b00: r = (a == b) ? 8'hFF : 8'h00;
               2'b01: r = (a < b) ? 8'hFF : 8'h00;
               2'b10: r = (a > b) ? 8'hFF : 8'h00;
               default: r = 8'h00;
             endcase
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic rstA_n = 1'b0, rstB_n = 1'b0, rstC_n = 1'b0;

  logic       reqA0 = 0, reqA1 = 0, gntA0, gntA1, doneA0, doneA1, errA, busyA;
  logic [3:0] opA0 = 0, opA1 = 0;
  logic [7:0] aA0 = 0, bA0 = 0, aA1 = 0, bA1 = 0, resultA, aluAA, aluBA, aluResA;
  logic [1:0] aluSelA, aluFnA;

  logic       reqB0 = 0, reqB1 = 0, gntB0, gntB1, doneB0, doneB1, errB, busyB;
  logic [3:0] opB0 = 0, opB1 = 0;
  logic [7:0] aB0 = 0, bB0 = 0, aB1 = 0, bB1 = 0, resultB, aluAB, aluBB, aluResB;
  logic [1:0] aluSelB, aluFnB;

  logic       reqC0 = 0, reqC1 = 0, gntC0, gntC1, doneC0, doneC1, errC, busyC;
  logic [3:0] opC0 = 0, opC1 = 0;
  logic [7:0] aC0 = 0, bC0 = 0, aC1 = 0, bC1 = 0, resultC, aluAC, aluBC, aluResC;
  logic [1:0] aluSelC, aluFnC;

  assign aluResA = aluModel(aluSelA, aluFnA, aluAA, aluBA);
  assign aluResB = aluModel(aluSelB, aluFnB, aluAB, aluBB);
  assign aluResC = aluModel(aluSelC, aluFnC, aluAC, aluBC);

  alu_arb_seq #(.LAT(1)) dutA (
    .clk(clk), .rst_n(rstA_n), .req0(reqA0), .req1(reqA1), .op0(opA0), .op1(opA1),
    .a0(aA0), .b0(bA0), .a1(aA1), .b1(bA1), .gnt0(gntA0), .gnt1(gntA1),
    .done0(doneA0), .done1(doneA1), .result(resultA), .err(errA), .busy(busyA),
    .alu_a(aluAA), .alu_b(aluBA), .alu_sel(aluSelA), .alu_fn(aluFnA), .alu_res(aluResA));

  alu_arb_seq #(.LAT(3)) dutB (
    .clk(clk), .rst_n(rstB_n), .req0(reqB0), .req1(reqB1), .op0(opB0), .op1(opB1),
    .a0(aB0), .b0(bB0), .a1(aB1), .b1(bB1), .gnt0(gntB0), .gnt1(gntB1),
    .done0(doneB0), .done1(doneB1), .result(resultB), .err(errB), .busy(busyB),
    .alu_a(aluAB), .alu_b(aluBB), .alu_sel(aluSelB), .alu_fn(aluFnB), .alu_res(aluResB));

  alu_arb_seq #(.LAT(4)) dutC (
    .clk(clk), .rst_n(rstC_n), .req0(reqC0), .req1(reqC1), .op0(opC0), .op1(opC1),
    .a0(aC0), .b0(bC0), .a1(aC1), .b1(bC1), .gnt0(gntC0), .gnt1(gntC1),
    .done0(doneC0), .done1(doneC1), .result(resultC), .err(errC), .busy(busyC),
    .alu_a(aluAC), .alu_b(aluBC), .alu_sel(aluSelC), .alu_fn(aluFnC), .alu_res(aluResC));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for instance A: every done pops one expected response.
  always @(negedge clk) begin
    expT e;
    if (rstA_n && (doneA0 || doneA1)) begin
      checkOutput("A.doneExclusive", {31'd0, doneA0 & doneA1}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("A.unexpectedDone", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("A.doneWho", {31'd0, doneA1}, {31'd0, e.who});
        checkOutput("A.result", {24'd0, resultA}, {24'd0, e.res});
        checkOutput("A.err", {31'd0, errA}, {31'd0, e.err});
      end
    end
    if (rstA_n && (gntA0 || gntA1))
      checkOutput("A.gntExclusive", {31'd0, gntA0 & gntA1}, 32'd0);
  end

  // One single-requester operation on instance A, starting in an IDLE cycle.
  task automatic applyStimulus(input vecT v);
    int gntCyc;
    bit seen;
    expT e;
    e.who = v.who; e.res = v.res; e.err = v.err;
    expQ.push_back(e);
    if (v.who) begin reqA1 = 1; opA1 = v.op; aA1 = v.a; bA1 = v.b; end
    else       begin reqA0 = 1; opA0 = v.op; aA0 = v.a; bA0 = v.b; end
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      nextCycle();
      if (gntA0 || gntA1) seen = 1;
    end
    checkOutput("A.vecGntSeen", {31'd0, seen}, 32'd1);
    checkOutput("A.vecGntWho", {31'd0, gntA1}, {31'd0, v.who});
    checkOutput("A.vecAluSel", {30'd0, aluSelA}, {30'd0, (v.op[3:2] == 2'b11) ? 2'b00 : v.op[3:2]});
    checkOutput("A.vecAluFn", {30'd0, aluFnA}, {30'd0, (v.op[3:2] == 2'b11) ? 2'b00 : v.op[1:0]});
    gntCyc = cyc;
    reqA0 = 0; reqA1 = 0; aA0 = 8'hA5; aA1 = 8'h5A;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      nextCycle();
      if (doneA0 || doneA1) seen = 1;
    end
    checkOutput("A.vecDoneSeen", {31'd0, seen}, 32'd1);
    checkOutput("A.vecLatency", cyc - gntCyc, 32'd1);
    nextCycle();
  endtask

  vecT vecs[$] = '{
    '{1'b0, 4'b1001, 8'h10, 8'h03, 8'h0D, 1'b0},
    '{1'b1, 4'b0100, 8'hF0, 8'h3C, 8'h30, 1'b0},
    '{1'b0, 4'b0101, 8'hF0, 8'h0F, 8'hFF, 1'b0},
    '{1'b1, 4'b0110, 8'h3C, 8'h00, 8'hC3, 1'b0},
    '{1'b0, 4'b0001, 8'h02, 8'h09, 8'hFF, 1'b0},
    '{1'b1, 4'b0000, 8'h07, 8'h08, 8'h00, 1'b0},
    '{1'b1, 4'b1101, 8'h5A, 8'h5A, 8'h00, 1'b1},
    '{1'b0, 4'b1111, 8'h01, 8'h02, 8'h00, 1'b1},
    '{1'b0, 4'b1000, 8'hFF, 8'h01, 8'h00, 1'b0}
  };

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  gntCyc[4];
    bit  gntWho[4];
    int  grants;
    int  t0;
    bit  seen;
    bit  sawDone;
    expT e;

    nextCycle();
    nextCycle();
    checkOutput("A.rstOutputs", {gntA0, gntA1, doneA0, doneA1, errA, busyA}, 32'd0);
    checkOutput("A.rstResult", {24'd0, resultA}, 32'd0);
    checkOutput("A.rstAlu", {12'd0, aluAA, aluBA, aluSelA, aluFnA}, 32'd0);
    rstA_n = 1; rstB_n = 1; rstC_n = 1;
    nextCycle();

    // LAT=1 add: gnt in cycle 1, done in cycle 2; operand change after gnt is ignored.
    e.who = 0; e.res = 8'h17; e.err = 0;
    expQ.push_back(e);
    reqA0 = 1; opA0 = 4'b1000; aA0 = 8'h12; bA0 = 8'h05;
    nextCycle();
    checkOutput("A.addGnt0", {gntA1, gntA0}, 32'd1);
    checkOutput("A.addAluSel", {30'd0, aluSelA}, 32'd2);
    checkOutput("A.addAluOps", {16'd0, aluAA, aluBA}, 32'h1205);
    checkOutput("A.addBusy1", {31'd0, busyA}, 32'd1);
    reqA0 = 0; aA0 = 8'hEE;
    nextCycle();
    checkOutput("A.addDone0", {doneA1, doneA0}, 32'd1);
    checkOutput("A.addAluIdle", {12'd0, aluAA, aluBA, aluSelA, aluFnA}, 32'd0);
    nextCycle();
    checkOutput("A.addBusyOff", {29'd0, busyA, doneA0, doneA1}, 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Both requesters held high from reset.
    rstA_n = 0;
    nextCycle();
    rstA_n = 1;
    nextCycle();
`ifdef ALU_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      e.who = i[0]; e.res = i[0] ? 8'h0D : 8'h07; e.err = 0;
      expQ.push_back(e);
    end
`else
    for (int i = 0; i < 4; i++) begin
      e.who = 0; e.res = 8'h07; e.err = 0;
      expQ.push_back(e);
    end
`endif
    reqA0 = 1; opA0 = 4'b1000; aA0 = 8'h03; bA0 = 8'h04;
    reqA1 = 1; opA1 = 4'b1001; aA1 = 8'h10; bA1 = 8'h03;
    grants = 0;
    for (int i = 0; i < 20 && grants < 4; i++) begin
      nextCycle();
      if (gntA0 || gntA1) begin
        gntCyc[grants] = cyc;
        gntWho[grants] = gntA1;
        grants++;
      end
    end
    reqA0 = 0; reqA1 = 0;
    checkOutput("A.arbGrantCount", grants, 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      checkOutput("A.arbOrderRR", {31'd0, gntWho[i]}, {31'd0, i[0]});
`else
      checkOutput("A.arbOrderFixed", {31'd0, gntWho[i]}, 32'd0);
`endif
      if (i > 0) checkOutput("A.arbSpacing", gntCyc[i] - gntCyc[i-1], 32'd3);
    end
    nextCycle();
    nextCycle();
    nextCycle();

    // LAT=3 single request: cycle-by-cycle view.
    reqB0 = 1; opB0 = 4'b1000; aB0 = 8'h20; bB0 = 8'h22;
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      checkOutput("B.gnt0", {31'd0, gntB0}, {31'd0, c == 1});
      checkOutput("B.busy", {31'd0, busyB}, {31'd0, c <= 4});
      checkOutput("B.aluOps", {12'd0, aluAB, aluBB, aluSelB, aluFnB},
                  (c <= 3) ? {12'd0, 8'h20, 8'h22, 2'b10, 2'b00} : 32'd0);
      checkOutput("B.done0", {31'd0, doneB0}, {31'd0, c == 4});
      if (c == 4) checkOutput("B.result", {23'd0, errB, resultB}, 32'h042);
      if (c == 1) begin reqB0 = 0; aB0 = 8'h99; end
    end

    // LAT=4: reset asserted in cycle 2 of an operation.
    nextCycle();
    reqC0 = 1; opC0 = 4'b1000; aC0 = 8'h01; bC0 = 8'h02;
    nextCycle();
    checkOutput("C.gnt0", {31'd0, gntC0}, 32'd1);
    reqC0 = 0;
    nextCycle();
    checkOutput("C.busyBeforeRst", {31'd0, busyC}, 32'd1);
    rstC_n = 0;
    #1;
    checkOutput("C.rstOutputs", {gntC0, gntC1, doneC0, doneC1, errC, busyC}, 32'd0);
    checkOutput("C.rstAlu", {12'd0, aluAC, aluBC, aluSelC, aluFnC}, 32'd0);
    checkOutput("C.rstResult", {24'd0, resultC}, 32'd0);
    sawDone = 0;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      if (i == 1) rstC_n = 1;
      if (doneC0 || doneC1) sawDone = 1;
    end
    checkOutput("C.noDoneAfterAbort", {31'd0, sawDone}, 32'd0);
    reqC0 = 1; reqC1 = 1; opC1 = 4'b1001; aC1 = 8'h09; bC1 = 8'h01;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      nextCycle();
      if (gntC0 || gntC1) seen = 1;
    end
    checkOutput("C.firstGntAfterRst", {30'd0, gntC1, gntC0}, 32'd1);
    t0 = cyc;
    reqC0 = 0; reqC1 = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      nextCycle();
      if (doneC0 || doneC1) seen = 1;
    end
    checkOutput("C.done0", {30'd0, doneC1, doneC0}, 32'd1);
    checkOutput("C.latency", cyc - t0, 32'd4);
    checkOutput("C.result", {24'd0, resultC}, 32'h03);

    nextCycle();
    checkOutput("A.queueEmpty", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arb_seq.md
# alu_arb_seq

Sequencer and arbiter for the 8-bit Power ALU: two requesters share one ALU datapath (compare, and/or/not, add/sub units behind the result mux). The block accepts one operation at a time and drives operands, unit select and sub-function to the ALU. It waits a fixed result latency, captures the mux output and returns it to the winning requester with a one-cycle done pulse. It sits between the requester pipelines and the ALU units plus result mux.

## Interface
- LAT, 1: ALU result latency in cycles, from operands presented to result stable at `alu_res`; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  level request from requester 0 / 1.
- op0, op1  in  4  operation: [3:2] unit select, [1:0] unit sub-function.
- a0, b0, a1, b1  in  8  operands of requester 0 / 1.
- gnt0, gnt1  out  1  one-cycle pulse: request accepted and operands sampled.
- done0, done1  out  1  one-cycle pulse: `result` valid for that requester.
- result  out  8  captured ALU result; held until the next capture.
- err  out  1  one-cycle pulse with done: the operation was illegal.
- busy  out  1  high in every state except IDLE.
- alu_a, alu_b  out  8  operands to the ALU units.
- alu_sel  out  2  result mux control: 00 compare, 01 andornot, 10 addsub.
- alu_fn  out  2  sub-function to the selected unit.
- alu_res  in  8  result mux output.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - If any req is high, select the winner (see Configuration) and latch its op, a and b into internal registers.
  - Pulse the winner's gnt, load the latency counter with LAT-1, go to EXEC.
  - With no request, stay in IDLE.
- EXEC:
  - alu_a, alu_b, alu_sel and alu_fn are driven from the latched registers.
  - The counter decrements each cycle.
  - On the cycle the counter is 0: capture alu_res into result, go to DONE.
- DONE:
  - Pulse done for the granted requester; update the last-grant pointer; return to IDLE.
  - Requests are ignored in this state.
- Illegal op (op[3:2]=11):
  - Sequenced normally, with alu_sel driven 00 and alu_fn 00.
  - result is captured as 8'h00, not from alu_res, and err pulses with done.
- Outside EXEC, alu_a, alu_b, alu_sel and alu_fn are 0.
- Requester rule: hold req and operands stable until gnt; deassert req in the cycle after done. A req still high when DONE returns to IDLE is a new request.
- Operands that change after gnt have no effect on the operation in flight.

## Timing
- Reset values: gnt0, gnt1, done0, done1, err, busy = 0; result = 8'h00; alu_* = 0; state IDLE; last-grant pointer = 1, so requester 0 wins first.
- Reset is asynchronous. Asserting it mid-operation aborts the operation immediately, with no done.
- Sequence, with cycle 0 = IDLE cycle with req high:
  - gnt high in cycle 1.
  - EXEC occupies cycles 1..LAT; alu_res is sampled at the end of cycle LAT.
  - done, err and the updated result are visible in cycle LAT+1.
- Accept-to-done latency is LAT+1 cycles. The earliest next gnt is cycle LAT+3, giving one operation per LAT+2 cycles.
- busy is high in cycles 1..LAT+1.
- gnt0/gnt1 and done0/done1 are mutually exclusive.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests the requester not in the last-grant pointer wins; the pointer updates in DONE.
- ALU_ARB_RR_EN undefined: fixed priority, req0 always wins over req1. The pointer register is omitted.

## Test plan
- Reset, LAT=1: req0, op0=4'b1000, a0=8'h12, b0=8'h05, with alu_res modelled as a+b.
  - Required: gnt0 in cycle 1; alu_sel=10 in cycle 1; done0 in cycle 2 with result=8'h17, err=0.
- LAT=3, single request:
  - Required: done in cycle 4; alu_* held constant over cycles 1..3; busy high in cycles 1..4.
- Round-robin (RR_EN): req0 and req1 held high continuously.
  - Required: grant order 0,1,0,1; gnt pulses 3 cycles apart at LAT=1.
- Fixed priority (RR_EN undefined): same stimulus as the round-robin case.
  - Required: only gnt0 ever pulses.
- Illegal op: op1=4'b1101 with alu_res=8'hFF.
  - Required: done1 with result=8'h00 and err=1.
- Reset mid-EXEC, LAT=4: rst_n low in cycle 2.
  - Required: all outputs 0 immediately and no done. After release, req0 is granted first.
